// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: drains 16-bit words from the hit FIFO and sends each over 8N1 UART, high byte first
// Ports: clk100/rst (async, active-high) | RD_EMPTY, RD_VALID, OTUBE from the FIFO read side |
//        RD_EN one-cycle read pulse | TX serial line (idle high) | BUSY not-idle flag |
//        WORD_COUNT words fully sent (wraps) | UNDERRUN sticky read-timeout flag
module fifo_uart_drain #(
  parameter int BAUD_DIV = 868,
  parameter int VALID_TIMEOUT = 8
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        RD_EMPTY,
  input  logic        RD_VALID,
  input  logic [15:0] OTUBE,
  output logic        RD_EN,
  output logic        TX,
  output logic        BUSY,
  output logic [15:0] WORD_COUNT,
  output logic        UNDERRUN
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_VALID, SEND_HI, SEND_LO} state_t;
  state_t state, nxt;
  logic [15:0] baud, hold, tmo;
  logic [3:0] bit_idx;
  logic [9:0] frame;
  logic sending, bit_end, frame_end, timeout;
  // frame bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit
  always_comb begin
    sending = state == SEND_HI || state == SEND_LO;
    bit_end = baud == 16'(BAUD_DIV - 1);
    frame_end = bit_end && bit_idx == 4'd9;
    timeout = tmo == 16'(VALID_TIMEOUT - 1);
    frame = {1'b1, state == SEND_HI ? hold[15:8] : hold[7:0], 1'b0};
    RD_EN = state == REQ;
    BUSY = state != IDLE;
    TX = sending ? frame[bit_idx] : 1'b1;
    nxt = state;
    case (state)
      IDLE:       nxt = RD_EMPTY ? IDLE : REQ;
      REQ:        nxt = WAIT_VALID;
      WAIT_VALID: nxt = RD_VALID ? SEND_HI : timeout ? IDLE : WAIT_VALID;
      SEND_HI:    nxt = frame_end ? SEND_LO : SEND_HI;
      SEND_LO:    nxt = frame_end ? IDLE : SEND_LO;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk100 or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // baud and bit index sit at zero outside the send states, so every frame starts from a clean reload
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      baud <= '0;
      bit_idx <= '0;
      hold <= '0;
      tmo <= '0;
      WORD_COUNT <= '0;
      UNDERRUN <= 1'b0;
    end else begin
      tmo <= state == WAIT_VALID ? tmo + 16'd1 : 16'd0;
      baud <= sending && !bit_end ? baud + 16'd1 : 16'd0;
      bit_idx <= !sending ? 4'd0 : !bit_end ? bit_idx : frame_end ? 4'd0 : bit_idx + 4'd1;
      if (state == WAIT_VALID && RD_VALID) hold <= OTUBE;
      if (state == SEND_LO && frame_end) WORD_COUNT <= WORD_COUNT + 16'd1;
      if (state == WAIT_VALID && !RD_VALID && timeout) UNDERRUN <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: directed bench with a FIFO model and a UART receiver for fifo_uart_drain
module tb_fifo_uart_drain;
  localparam int B = 4;
  logic clk100 = 1'b0, rst = 1'b1, RD_EMPTY = 1'b1, RD_VALID = 1'b0;
  logic [15:0] OTUBE = '0;
  logic RD_EN, TX, BUSY, UNDERRUN;
  logic [15:0] WORD_COUNT;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, en_cnt = 0, ferr = 0;
  logic [15:0] fq[$];
  logic [7:0] rx_q[$];
  int rx_t[$];
  logic pend = 1'b0, stray = 1'b0, no_valid = 1'b0;
  logic [15:0] pend_w = '0;
  logic rx_act = 1'b0;
  int rx_n = 0;
  logic [7:0] rx_b = '0;

  fifo_uart_drain #(.BAUD_DIV(B), .VALID_TIMEOUT(8)) dut (
    .clk100(clk100), .rst(rst), .RD_EMPTY(RD_EMPTY), .RD_VALID(RD_VALID), .OTUBE(OTUBE),
    .RD_EN(RD_EN), .TX(TX), .BUSY(BUSY), .WORD_COUNT(WORD_COUNT), .UNDERRUN(UNDERRUN)
  );

  always #5 clk100 = ~clk100;

  // standard-mode FIFO: data valid one cycle after the RD_EN cycle
  always @(negedge clk100) begin
    cyc <= cyc + 1;
    en_cnt <= en_cnt + (RD_EN ? 1 : 0);
    RD_VALID <= pend | stray;
    OTUBE <= pend ? pend_w : 16'hBEEF;
    pend <= RD_EN && fq.size() != 0 && !no_valid;
    if (RD_EN && fq.size() != 0 && !no_valid) begin
      pend_w <= fq[0];
      fq.delete(0);
    end
    RD_EMPTY <= fq.size() == 0;
  end

  // receiver samples mid-bit, counting negedges from the first low start-bit cycle
  always @(negedge clk100) begin
    if (rst) rx_act <= 1'b0;
    else if (!rx_act) begin
      if (!TX) begin
        rx_act <= 1'b1;
        rx_n <= 1;
        rx_t.push_back(cyc);
      end
    end else begin
      rx_n <= rx_n + 1;
      if (rx_n > B && rx_n < 9 * B && rx_n % B == B / 2) rx_b <= {TX, rx_b[7:1]};
      if (rx_n == 9 * B + B / 2) begin
        if (!TX) ferr <= ferr + 1;
        rx_q.push_back(rx_b);
        rx_act <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk100);
  endtask

  task automatic wait_en(output int c);
    int k = 0;
    do begin
      @(negedge clk100);
      k++;
    end while (!RD_EN && k < 200);
    c = cyc;
    chk("rd_en_seen", 32'(RD_EN), 1);
  endtask

  task automatic wait_idle(input logic [15:0] wc);
    int k = 0;
    do begin
      @(negedge clk100);
      k++;
    end while (!(WORD_COUNT == wc && !BUSY) && k < 2000);
    chk("word_count", 32'(WORD_COUNT), 32'(wc));
    chk("idle", 32'(BUSY), 0);
  endtask

  task automatic do_reset();
    @(posedge clk100);
    #2 rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic chk_rx(input int idx, input logic [7:0] e);
    chk("rx_byte", 32'(rx_q[idx]), 32'(e));
  endtask

  // entered at the negedge of the WAIT_VALID cycle; checks all 20 bit periods of a word
  task automatic chk_word(input logic [15:0] w);
    logic [9:0] f;
    logic [B-1:0] nib;
    for (int y = 0; y < 2; y++) begin
      f = {1'b1, y == 0 ? w[15:8] : w[7:0], 1'b0};
      for (int j = 0; j < 10; j++) begin
        for (int k = 0; k < B; k++) begin
          @(negedge clk100);
          nib[k] = TX;
        end
        chk("tx_bit", 32'(nib), 32'({B{f[j]}}));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int c, b, e, tr;
    fq.push_back(16'hA503);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk100);
      chk("rst_tx", 32'(TX), 1);
      chk("rst_rd_en", 32'(RD_EN), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_wc", 32'(WORD_COUNT), 0);
      chk("rst_ur", 32'(UNDERRUN), 0);
    end
    rst = 1'b0;

    wait_en(c);
    @(negedge clk100);
    chk("wait_busy", 32'(BUSY), 1);
    chk("wait_tx", 32'(TX), 1);
    chk_word(16'hA503);
    chk("wc_last_cycle", 32'(WORD_COUNT), 0);
    chk("busy_last_cycle", 32'(BUSY), 1);
    tick();
    chk("wc_single", 32'(WORD_COUNT), 1);
    chk("idle_single", 32'(BUSY), 0);
    chk("en_single", 32'(en_cnt), 1);
    chk_rx(0, 8'hA5);
    chk_rx(1, 8'h03);

    do_reset();
    b = rx_q.size();
    tr = rx_t.size();
    e = en_cnt;
    fq.push_back(16'h0101);
    fq.push_back(16'hFFFF);
    fq.push_back(16'h8000);
    wait_idle(16'd3);
    tick(20);
    chk("en_b2b", 32'(en_cnt - e), 3);
    chk("rx_count_b2b", 32'(rx_q.size() - b), 6);
    chk_rx(b, 8'h01);
    chk_rx(b + 1, 8'h01);
    chk_rx(b + 2, 8'hFF);
    chk_rx(b + 3, 8'hFF);
    chk_rx(b + 4, 8'h80);
    chk_rx(b + 5, 8'h00);
    chk("frame_len", 32'(rx_t[tr + 1] - rx_t[tr]), 32'(10 * B));
    chk("gap_1", 32'(rx_t[tr + 2] - rx_t[tr + 1]), 32'(10 * B + 3));
    chk("gap_2", 32'(rx_t[tr + 4] - rx_t[tr + 3]), 32'(10 * B + 3));
    chk("framing", 32'(ferr), 0);

    do_reset();
    chk("ur_after_rst", 32'(UNDERRUN), 0);
    no_valid = 1'b1;
    fq.push_back(16'h0BAD);
    tr = rx_t.size();
    wait_en(c);
    tick(8);
    chk("ur_early", 32'(UNDERRUN), 0);
    tick();
    chk("ur_set", 32'(UNDERRUN), 1);
    chk("ur_idle", 32'(BUSY), 0);
    tick();
    chk("re_request", 32'(RD_EN), 1);
    tick(30);
    chk("ur_sticky", 32'(UNDERRUN), 1);
    chk("ur_no_tx", 32'(rx_t.size() - tr), 0);
    fq.delete();
    tick(20);
    chk("ur_sticky_idle", 32'(UNDERRUN), 1);
    chk("ur_final_idle", 32'(BUSY), 0);
    no_valid = 1'b0;

    do_reset();
    chk("ur_cleared", 32'(UNDERRUN), 0);
    b = rx_q.size();
    fq.push_back(16'h1234);
    wait_en(c);
    tick(59);
    chk("pre_rst_tx", 32'(TX), 0);
    chk("pre_rst_busy", 32'(BUSY), 1);
    chk("pre_rst_wc", 32'(WORD_COUNT), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(TX), 1);
    chk("mid_rst_busy", 32'(BUSY), 0);
    chk("mid_rst_wc", 32'(WORD_COUNT), 0);
    tick(3);
    rst = 1'b0;
    chk("hi_byte_before_rst", 32'(rx_q.size() - b), 1);
    chk_rx(b, 8'h12);
    b = rx_q.size();
    fq.push_back(16'h5678);
    wait_idle(16'd1);
    chk("rx_count_after_rst", 32'(rx_q.size() - b), 2);
    chk_rx(b, 8'h56);
    chk_rx(b + 1, 8'h78);

    do_reset();
    tr = rx_t.size();
    e = en_cnt;
    @(posedge clk100);
    #1 stray = 1'b1;
    @(posedge clk100);
    #1 stray = 1'b0;
    tick(20);
    chk("stray_busy", 32'(BUSY), 0);
    chk("stray_tx", 32'(rx_t.size() - tr), 0);
    chk("stray_en", 32'(en_cnt - e), 0);
    chk("stray_wc", 32'(WORD_COUNT), 0);
    force dut.WORD_COUNT = 16'hFFFF;
    tick();
    release dut.WORD_COUNT;
    tick();
    chk("wc_preset", 32'(WORD_COUNT), 32'hFFFF);
    b = rx_q.size();
    fq.push_back(16'h4242);
    wait_idle(16'h0000);
    chk_rx(b, 8'h42);
    chk_rx(b + 1, 8'h42);
    chk("framing_end", 32'(ferr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
